// File: rtl/hgcal_input_quantizer.sv
// Quantizes a valid/ready stream of raw HGCAL cell samples to Q_W-bit codes and packs
// one frame of N_IN codes into a double-buffered flat vector for the layer0 LUTs.
module hgcal_input_quantizer #(
    parameter int N_IN     = 48,
    parameter int SAMPLE_W = 8,
    parameter int Q_W      = 2,
    parameter int SHIFT    = 4,
    parameter int ERR_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [SAMPLE_W-1:0]   s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [N_IN*Q_W-1:0]   m_data,
    output logic                  err_pulse,
    output logic [ERR_W-1:0]      err_cnt
);

    localparam int DATA_W   = N_IN * Q_W;
    localparam int IDX_W    = $clog2(N_IN);
    localparam int CODE_MAX = (1 << Q_W) - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   asm_q, asm_d, asm_wr;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                err_pulse_q;
    logic [ERR_W-1:0]    err_cnt_q;

    logic                accept;
    logic                slot_free;
    logic                wr_en;
    logic                load_fill;
    logic                load_hold;
    logic                err;
    logic [SAMPLE_W-1:0] q_shift;
    logic [Q_W-1:0]      code;

    assign s_ready   = (state_q == FILL) || (state_q == DRAIN);
    assign accept    = s_valid && s_ready;
    assign slot_free = !m_valid_q || m_ready;

    // Truncating shift, then clamp to the largest code.
    assign q_shift = s_data >> SHIFT;
    assign code    = (q_shift > SAMPLE_W'(CODE_MAX)) ? Q_W'(CODE_MAX) : q_shift[Q_W-1:0];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        wr_en     = 1'b0;
        load_fill = 1'b0;
        load_hold = 1'b0;
        err       = 1'b0;

        asm_wr = asm_q;
        asm_wr[idx_q*Q_W +: Q_W] = code;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (!s_last) begin
                            err     = 1'b1;
                            state_d = DRAIN;
                        end else if (slot_free) begin
                            load_fill = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else if (s_last) begin
                        err   = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    load_hold = 1'b1;
                    state_d   = FILL;
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_d = FILL;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase

        asm_d = wr_en ? asm_wr : asm_q;

        // The frame that completes this cycle includes the sample being written now.
        if (load_fill) begin
            m_data_d = asm_wr;
        end else if (load_hold) begin
            m_data_d = asm_q;
        end else begin
            m_data_d = m_data_q;
        end

        if (load_fill || load_hold) begin
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q     <= state_d;
            idx_q       <= idx_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            err_pulse_q <= err;
            if (err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
        end
    end

    // NOTE: the assembly buffer is not reset; unwritten slots are never exposed because
    // a frame only reaches m_data after all N_IN slots have been written.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule
